// File: rtl/lcd_hd44780_drv.sv
// lcd_hd44780_drv -- HD44780-compatible character-LCD driver.
//
// Waits out the controller power-on time, optionally emits the controller
// init sequence, then drains a command/data write FIFO onto the 8-bit LCD
// bus. Each byte gets a setup clock, an E pulse of T_EN clocks, a hold clock
// and an execution wait (T_CLR for clear/home, T_CMD otherwise).
//
// Optional feature: define LCD_INIT_EN to compile in the INIT state and the
// 4-byte init ROM (0x38, 0x0C, 0x06, 0x01). Without it PWR_WAIT goes
// straight to IDLE and the producer must send the init bytes itself.
//
// Ports:
//   SYS_clk     in   clock
//   SYS_reset   in   asynchronous active-low reset
//   wr_valid    in   producer byte offered
//   wr_rs       in   register select of offered byte (0 cmd, 1 data)
//   wr_data     in   offered byte
//   wr_ready    out  FIFO not full
//   pin[14:4]   out  LCD bus: 4 RS, 5 RW (always 0), 6 E, 14:7 D7..D0
//   state       out  FSM state code, zero-extended to 6 bits
//   busy        out  high in every state except IDLE
//   fifo_level  out  FIFO occupancy
module lcd_hd44780_drv #(
    parameter int T_PWR      = 20000,
    parameter int T_EN       = 12,
    parameter int T_CMD      = 2000,
    parameter int T_CLR      = 80000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          SYS_clk,
    input  logic                          SYS_reset,
    input  logic                          wr_valid,
    input  logic                          wr_rs,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic [14:4]                   pin,
    output logic [5:0]                    state,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int TM1  = (T_PWR > T_CLR) ? T_PWR : T_CLR;
    localparam int TM2  = (T_CMD > T_EN) ? T_CMD : T_EN;
    localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
    localparam int CW   = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {
        S_PWR_WAIT = 3'd0,
        S_INIT     = 3'd1,
        S_SETUP    = 3'd2,
        S_EN_HIGH  = 3'd3,
        S_HOLD     = 3'd4,
        S_WAIT     = 3'd5,
        S_IDLE     = 3'd6,
        S_POP      = 3'd7
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            rs_q;
    logic            e_q;
    logic [7:0]      d_q;
    logic            busy_q;

    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic            wr_ready_q;
    logic            push;
    logic            pop;
    logic            is_long;

`ifdef LCD_INIT_EN
    logic [2:0]      init_idx_q;
    logic            init_act_q;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction
`endif

    // ---------------------------------------------------------------- FIFO
    assign push = wr_valid && wr_ready_q;
    assign pop  = (state_q == S_POP);

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge SYS_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_rs, wr_data};
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            wr_ready_q <= (level_d != LW'(FIFO_DEPTH));
        end
    end

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    assign is_long = !rs_q && (d_q[7:2] == 6'd0) && (d_q != 8'd0);

    // ----------------------------------------------------------------- FSM
    // busy_q is updated on every transition into or out of IDLE so that it
    // tracks state_q without a combinational decode.
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q    <= S_PWR_WAIT;
            cnt_q      <= CW'(T_PWR - 1);
            rs_q       <= 1'b0;
            e_q        <= 1'b0;
            d_q        <= '0;
            busy_q     <= 1'b1;
`ifdef LCD_INIT_EN
            init_idx_q <= '0;
            init_act_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_PWR_WAIT: begin
                    if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
                        state_q    <= S_INIT;
                        init_act_q <= 1'b1;
`else
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_INIT: begin
`ifdef LCD_INIT_EN
                    rs_q       <= 1'b0;
                    d_q        <= init_byte(init_idx_q[1:0]);
                    init_idx_q <= init_idx_q + 3'd1;
                    state_q    <= S_SETUP;
`else
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
`endif
                end
                S_IDLE: begin
                    if (level_q != '0) begin
                        state_q <= S_POP;
                        busy_q  <= 1'b1;
                    end
                end
                S_POP: begin
                    rs_q    <= mem_q[rd_ptr_q][8];
                    d_q     <= mem_q[rd_ptr_q][7:0];
                    state_q <= S_SETUP;
                end
                S_SETUP: begin
                    e_q     <= 1'b1;
                    cnt_q   <= CW'(T_EN - 1);
                    state_q <= S_EN_HIGH;
                end
                S_EN_HIGH: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b0;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_HOLD: begin
                    cnt_q   <= is_long ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
                        if (init_act_q && (init_idx_q != 3'd4)) begin
                            state_q <= S_INIT;
                        end else begin
                            init_act_q <= 1'b0;
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                        end
`else
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pin        = {d_q, e_q, 1'b0, rs_q};
    assign state      = {3'b000, state_q};
    assign busy       = busy_q;
    assign wr_ready   = wr_ready_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_lcd_hd44780_drv.sv
module tb_lcd_hd44780_drv;

    localparam int T_PWR = 20;
    localparam int T_EN  = 4;
    localparam int T_CMD = 8;
    localparam int T_CLR = 30;
    localparam int DEPTH = 4;

    logic        SYS_clk;
    logic        SYS_reset;
    logic        wr_valid;
    logic        wr_rs;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic [14:4] pin;
    logic [5:0]  state;
    logic        busy;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    lcd_hd44780_drv #(
        .T_PWR(T_PWR), .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR), .FIFO_DEPTH(DEPTH)
    ) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .wr_valid(wr_valid), .wr_rs(wr_rs),
        .wr_data(wr_data), .wr_ready(wr_ready), .pin(pin), .state(state), .busy(busy),
        .fifo_level(fifo_level)
    );

    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_long(input logic [8:0] b);
        return (b[8] == 1'b0) && (b[7:2] == 6'd0) && (b[7:0] != 8'd0);
    endfunction

    // Drive one byte for one clock; the expected wr_ready decides whether
    // the byte joins the scoreboard.
    task automatic push_byte(input logic rs, input logic [7:0] d, input logic acc);
        check("wr_ready", wr_ready, acc);
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        if (acc) exp_q.push_back({rs, d});
        @(negedge SYS_clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [5:0] tgt, input int max_cyc, input string tag);
        int n = 0;
        while (state !== tgt && n < max_cyc) begin
            @(negedge SYS_clk);
            n++;
        end
        check(tag, state, tgt);
    endtask

    task automatic wait_drained(input int max_cyc, input string tag);
        int n = 0;
        while (!(state === 6'd6 && fifo_level === 3'd0) && n < max_cyc) begin
            @(negedge SYS_clk);
            n++;
        end
        check(tag, {state, fifo_level}, {6'd6, 3'd0});
    endtask

    task automatic push_init_expect();
`ifdef LCD_INIT_EN
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
`endif
    endtask

    // Bus monitor: pops the scoreboard on each E rise, checks E width, byte
    // hold through the pulse, and the execution wait for that byte.
    logic       prev_e;
    int         e_cnt;
    int         w_cnt;
    logic [8:0] cur;

    initial begin
        prev_e = 1'b0;
        e_cnt  = 0;
        w_cnt  = 0;
        cur    = '0;
    end

    always @(negedge SYS_clk) begin
        if (!SYS_reset) begin
            prev_e = 1'b0;
            e_cnt  = 0;
            w_cnt  = 0;
        end else begin
            if (pin[6] && !prev_e) begin
                check("byte_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("bus_byte", {pin[4], pin[14:7]}, cur);
                end
                check("rw_low", pin[5], 0);
                e_cnt = 1;
            end else if (pin[6]) begin
                e_cnt++;
            end
            if (!pin[6] && prev_e) begin
                check("e_width", e_cnt, T_EN);
                check("hold_byte", {pin[4], pin[14:7]}, cur);
            end
            if (state === 6'd5) begin
                w_cnt++;
            end else if (w_cnt != 0) begin
                check("wait_len", w_cnt, is_long(cur) ? T_CLR : T_CMD);
                w_cnt = 0;
            end
            prev_e = pin[6];
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        SYS_reset = 1'b0;
        wr_valid  = 1'b0;
        wr_rs     = 1'b0;
        wr_data   = '0;

        // Reset and power-on wait
        repeat (5) @(posedge SYS_clk);
        @(negedge SYS_clk);
        check("rst_pin", pin, 0);
        check("rst_state", state, 0);
        check("rst_busy", busy, 1);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_level", fifo_level, 0);
        SYS_reset = 1'b1;
        push_init_expect();
        repeat (T_PWR - 1) @(posedge SYS_clk);
        @(negedge SYS_clk);
        check("pwr_wait_hold", state, 0);
        @(posedge SYS_clk);
        @(negedge SYS_clk);
`ifdef LCD_INIT_EN
        check("pwr_wait_exit", state, 1);
`else
        check("pwr_wait_exit", state, 6);
`endif
        wait_drained(400, "init_done");
        check("idle_busy", busy, 0);

        // Data write: latency and bus cycle length
        push_byte(1'b1, 8'h41, 1'b1);
        check("push_level", fifo_level, 1);
        check("push_state_idle", state, 6);
        @(negedge SYS_clk);
        check("pop_state", state, 7);
        @(negedge SYS_clk);
        check("data_d", pin[14:7], 8'h41);
        check("data_rs", pin[4], 1);
        check("setup_e", pin[6], 0);
        repeat (13) @(negedge SYS_clk);
        check("busy_before_end", busy, 1);
        @(negedge SYS_clk);
        check("busy_end", busy, 0);
        check("idle_after_write", state, 6);

        // Long command followed by FIFO fill while the FIFO is not drained
        push_byte(1'b0, 8'h02, 1'b1);
        wait_state(6'd5, 40, "reach_wait");
        push_byte(1'b1, 8'h31, 1'b1);
        push_byte(1'b1, 8'h32, 1'b1);
        push_byte(1'b1, 8'h33, 1'b1);
        push_byte(1'b1, 8'h34, 1'b1);
        check("full_level", fifo_level, 4);
        push_byte(1'b1, 8'h35, 1'b0);
        push_byte(1'b1, 8'h36, 1'b0);
        check("full_level_kept", fifo_level, 4);
        wait_drained(400, "drain_full");

        // Long/short boundary commands
        push_byte(1'b0, 8'h80, 1'b1);
        push_byte(1'b0, 8'h03, 1'b1);
        push_byte(1'b0, 8'h04, 1'b1);
        push_byte(1'b0, 8'h00, 1'b1);
        wait_drained(400, "drain_cmds");

        // Reset during an E pulse
        push_byte(1'b1, 8'h55, 1'b1);
        push_byte(1'b1, 8'h56, 1'b1);
        push_byte(1'b1, 8'h57, 1'b1);
        begin
            int n = 0;
            while (pin[6] !== 1'b1 && n < 40) begin
                @(negedge SYS_clk);
                n++;
            end
        end
        check("e_high_seen", pin[6], 1);
        check("level_before_reset", fifo_level, 2);
        @(posedge SYS_clk);
        #2;
        SYS_reset = 1'b0;
        #1;
        check("async_e_drop", pin[6], 0);
        check("async_pin", pin, 0);
        check("async_level", fifo_level, 0);
        check("async_state", state, 0);
        check("async_busy", busy, 1);
        exp_q.delete();
        repeat (3) @(negedge SYS_clk);
        SYS_reset = 1'b1;
        push_init_expect();
        repeat (T_PWR - 1) @(posedge SYS_clk);
        @(negedge SYS_clk);
        check("restart_hold", state, 0);
        @(posedge SYS_clk);
        @(negedge SYS_clk);
        check("restart_exit", (state != 6'd0), 1);
        wait_drained(400, "restart_done");
        repeat (5) @(negedge SYS_clk);
        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_drv.md
# lcd_hd44780_drv

Parametrised HD44780-compatible character-LCD driver: the next generation of the button-driven `lcd` block, generalising it from fixed messages to a buffered byte-stream interface. It performs the power-on wait and, optionally, the controller init sequence. It then drains a command/data FIFO to the 11-bit LCD pin bus with programmable enable-pulse and execution-wait timing. It sits between any user-logic producer (button decoder, text sequencer) and the board LCD header.

## Interface

Parameters:
- `T_PWR`, 20000: power-on wait after reset, in clocks.
- `T_EN`, 12: E high width, in clocks (≥1).
- `T_CMD`, 2000: post-write execution wait for ordinary commands and data, in clocks.
- `T_CLR`, 80000: post-write wait for clear (0x01) and home (0x02/0x03) commands, in clocks.
- `FIFO_DEPTH`, 16: write-FIFO entries; must be a power of 2, ≥2.

Ports:
- `SYS_clk` in 1: the block's single clock.
- `SYS_reset` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: a producer byte is offered.
- `wr_rs` in 1: register select for the offered byte (0 = command, 1 = data).
- `wr_data` in 8: the offered byte.
- `wr_ready` out 1: the FIFO can accept a byte (not full).
- `pin` out [14:4]: LCD bus. Bit 4 = RS, bit 5 = RW, bit 6 = E, bits 14:7 = D7..D0.
- `state` out 6: current FSM state code, zero-extended.
- `busy` out 1: high in every state except IDLE.
- `fifo_level` out clog2(FIFO_DEPTH)+1: occupancy of the FIFO.

## Operation

- Write-only bus: RW (pin[5]) is held at 0 at all times.
- FIFO accept rule: a byte is pushed when `wr_valid && wr_ready`, and `wr_ready = (fifo_level != FIFO_DEPTH)`.
- FIFO during init: the FIFO accepts bytes during PWR_WAIT and INIT; they are not consumed until IDLE.
- FSM states and codes:
  - PWR_WAIT (0): counts `T_PWR` clocks, then goes to INIT when `LCD_INIT_EN` is defined, otherwise to IDLE.
  - INIT (1): loads the next init byte (rs=0) from the fixed sequence 0x38, 0x0C, 0x06, 0x01, then goes to SETUP. After the 4th byte has completed its WAIT, the FSM goes to IDLE.
  - IDLE (6): if the FIFO is non-empty, goes to POP.
  - POP (7): latches the head byte into the output register and increments the read pointer, then goes to SETUP.
  - SETUP (2): RS/D driven, E=0, for 1 clock. Then goes to EN_HIGH.
  - EN_HIGH (3): E=1 for `T_EN` clocks. Then goes to HOLD.
  - HOLD (4): E=0, with RS/D held, for 1 clock. Then goes to WAIT.
  - WAIT (5): waits `T_CLR` clocks if the byte is a long command, otherwise `T_CMD` clocks. Then returns to INIT (while the init sequence is in progress) or to IDLE.
- Long-command rule: a byte is long when rs=0 and data[7:2]==0 and data!=0.
- RS and D hold: RS/D hold their last driven value until the next SETUP.
- Shared counter: a single down-counter is used, sized to clog2(max(T_PWR, T_CLR, T_CMD, T_EN))+1 bits.
- Simultaneous FIFO events: a push and a pop in the same clock leaves `fifo_level` unchanged. Pointers wrap modulo FIFO_DEPTH.
- Pushes to a full FIFO: a push attempted while full is ignored and the FIFO is unchanged.

## Timing

- Reset values (`SYS_reset`=0, asynchronous):
  - `pin` = 0, so E=0 immediately.
  - `state` = 0 (PWR_WAIT).
  - `busy` = 1.
  - `wr_ready` = 1.
  - `fifo_level` = 0, pointers cleared, init index = 0.
- Reset mid-operation: a reset during an E-high pulse aborts it, and any FIFO contents are discarded.
- Output timing: all outputs are registered.
- Bus cycle length per byte, from POP entry to IDLE: 1 (POP) + 1 (SETUP) + `T_EN` + 1 (HOLD) + `T_CMD` or `T_CLR` clocks.
- Minimum producer-to-bus latency: a push into an empty FIFO while in IDLE appears on D at 3 clocks after the push edge (FIFO write, IDLE sees non-empty, POP).
- FIFO visibility: `fifo_level` updates on the clock after the push.

## Configuration

- `LCD_INIT_EN` defined: after PWR_WAIT, the 4-byte init sequence is emitted before any FIFO byte. The sequence is 0x38 (8-bit, 2-line), 0x0C (display on), 0x06 (entry increment), 0x01 (clear, long wait).
- `LCD_INIT_EN` undefined: the INIT state and the init ROM are not compiled in, and PWR_WAIT goes directly to IDLE. The producer is responsible for sending the init bytes.

## Test plan

Bench parameters: T_PWR=20, T_EN=4, T_CMD=8, T_CLR=30, FIFO_DEPTH=4.

- **Reset/power-on:** hold `SYS_reset`=0 for 5 clocks, then release → `pin`=0, `state`=0 and `busy`=1 during reset; `state` leaves 0 exactly 20 clocks after release.
- **Init sequence (`LCD_INIT_EN` defined):** → D shows 0x38, 0x0C, 0x06, 0x01 with RS=0. Each E pulse is exactly 4 clocks. The gap after 0x01 is 30 clocks and the other gaps are 8 clocks. `state` then reaches 6.
- **Data write:** push rs=1, 0x41 in IDLE → D=0x41 and RS=1 three clocks later, E high for 4 clocks, RW=0, `busy` returns to 0 after a total of 15 clocks.
- **FIFO full:** push 6 bytes back-to-back while the FIFO is not being drained → `wr_ready`=0 after the 4th byte. Bytes 5 and 6 are dropped; bytes 1–4 appear in order.
- **Long command:** push rs=0, 0x02 → WAIT lasts 30 clocks. Then push rs=0, 0x80 → WAIT lasts 8 clocks.
- **Reset mid-pulse:** assert `SYS_reset`=0 while E=1 → E drops in the same clock (asynchronously), `fifo_level`=0, and the sequence restarts at PWR_WAIT.
